// File: rtl/tx_port.sv
// Output port of a small packet switch: round-robin arbiter over the rx heads
// feeding a circular output FIFO that is drained by the downstream sink.
`ifndef NUM_PORTS
`define NUM_PORTS 4
`endif

package tx_port_pkg;
  typedef struct packed {
    logic [`NUM_PORTS-1:0] target;
    logic [15:0]           payload;
  } packet_t;
endpackage

module tx_port
  import tx_port_pkg::*;
#(
  parameter int PORT_ID = 0,
  parameter int DEPTH   = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [`NUM_PORTS-1:0]           req_vec,
  input  packet_t [`NUM_PORTS-1:0]        pkt_vec,
  output logic [`NUM_PORTS-1:0]           grant_vec,
  output packet_t                         out_pkt,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(DEPTH):0]          occupancy
);

  localparam int N  = `NUM_PORTS;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(DEPTH);

  if (PORT_ID < 0 || PORT_ID >= N) begin : g_bad_port_id
    $error("tx_port: PORT_ID out of range");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("tx_port: DEPTH must be a power of two >= 2");
  end

  packet_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [PW-1:0]   last_ptr;
  logic [PW-1:0]   grant_idx;
  logic            full;
  logic            push;
  logic            pop;
  logic            found;
  int              idx;

  assign full      = (occupancy == (AW+1)'(DEPTH));
  assign out_valid = (occupancy != '0);
  assign out_pkt   = mem[rd_ptr];
  assign push      = |grant_vec;
  assign pop       = out_valid && out_ready;

  // Search starts just after the last winner and wraps; a full buffer withholds
  // the grant even when a pop frees a slot this cycle (no bypass path).
  always_comb begin
    grant_vec = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last_ptr) + off) % N;
      if (!found && req_vec[idx]) begin
        grant_vec[idx] = 1'b1;
        grant_idx      = PW'(idx);
        found          = 1'b1;
      end
    end
    if (rst || full) begin
      grant_vec = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pkt_vec[grant_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      last_ptr  <= PW'(N - 1);
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        last_ptr <= grant_idx;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_port.sv
// Directed bench for tx_port: stimulus pushes expected packets into a
// scoreboard queue, an independent monitor pops and compares at the output.
`ifndef NUM_PORTS
`define NUM_PORTS 4
`endif

module tb_tx_port;
  import tx_port_pkg::*;

  localparam int N     = `NUM_PORTS;
  localparam int DEPTH = 8;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [N-1:0]             req_vec = '0;
  packet_t [N-1:0]          pkt_vec;
  logic [N-1:0]             grant_vec;
  packet_t                  out_pkt;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [$clog2(DEPTH):0]   occupancy;

  packet_t sb_q[$];
  logic    pend_push = 1'b0;
  int      vec_count = 0;
  int      miss_count = 0;
  int      tag = 0;

  tx_port #(.PORT_ID(0), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vec   (req_vec),
    .pkt_vec   (pkt_vec),
    .grant_vec (grant_vec),
    .out_pkt   (out_pkt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every packet carries a fresh tag so reordering or stale entries are visible.
  task automatic drivePackets();
    tag++;
    for (int i = 0; i < N; i++) begin
      pkt_vec[i].target  = N'(tag + i);
      pkt_vec[i].payload = {12'(tag), 4'(i)};
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input logic rdy,
                               input logic [N-1:0] exp_grant, input int exp_occ);
    @(negedge clk);
    #1;
    drivePackets();
    req_vec   = req;
    out_ready = rdy;
    pend_push = 1'b0;
    #1;
    checkOutput("grant_vec", 32'(grant_vec), 32'(exp_grant));
    if (exp_occ >= 0) checkOutput("occupancy", 32'(occupancy), 32'(exp_occ));
    for (int i = 0; i < N; i++) begin
      if (exp_grant[i]) begin
        sb_q.push_back(pkt_vec[i]);
        pend_push = 1'b1;
      end
    end
  endtask

  task automatic doReset(input logic [N-1:0] req);
    @(negedge clk);
    #1;
    rst       = 1'b1;
    req_vec   = req;
    out_ready = 1'b1;
    pend_push = 1'b0;
    sb_q.delete();
    #1;
    checkOutput("grant_in_reset", 32'(grant_vec), 32'd0);
    @(negedge clk);
    #1;
    rst     = 1'b0;
    req_vec = '0;
    #1;
    checkOutput("occ_after_reset", 32'(occupancy), 32'd0);
    checkOutput("valid_after_reset", 32'(out_valid), 32'd0);
  endtask

  // Monitor: head must match the oldest expected packet whenever valid, and a
  // pop at the coming edge retires it.
  initial begin
    packet_t exp_pkt;
    logic    exp_valid;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        exp_valid = (sb_q.size() > (pend_push ? 1 : 0));
        checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
        if (out_valid && exp_valid) begin
          exp_pkt = sb_q[0];
          checkOutput("out_pkt", 32'(out_pkt), 32'(exp_pkt));
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    drivePackets();
    repeat (2) @(posedge clk);
    doReset(4'b1111);

    // Round-robin from reset: 0,1,2,3,0 with one-deep drain.
    applyStimulus(4'b1111, 1'b1, 4'b0001, 0);
    applyStimulus(4'b1111, 1'b1, 4'b0010, 1);
    applyStimulus(4'b1111, 1'b1, 4'b0100, 1);
    applyStimulus(4'b1111, 1'b1, 4'b1000, 1);
    applyStimulus(4'b1111, 1'b1, 4'b0001, 1);
    applyStimulus(4'b0000, 1'b1, 4'b0000, 1);
    applyStimulus(4'b0000, 1'b1, 4'b0000, 0);

    // Single request into an empty buffer, then pop, then empty with ready high.
    applyStimulus(4'b0100, 1'b1, 4'b0100, 0);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1);
    applyStimulus(4'b0000, 1'b1, 4'b0000, 1);
    applyStimulus(4'b0000, 1'b1, 4'b0000, 0);

    // Fill to full with the sink stalled; grant withheld once full.
    for (int k = 0; k < 10; k++)
      applyStimulus(4'b0001, 1'b0, (k < DEPTH) ? 4'b0001 : 4'b0000, (k < DEPTH) ? k : DEPTH);
    applyStimulus(4'b0001, 1'b1, 4'b0000, DEPTH);
    applyStimulus(4'b0001, 1'b1, 4'b0001, DEPTH - 1);

    // Steady push/pop across several pointer wraps.
    for (int k = 0; k < 28; k++)
      applyStimulus(4'b1111, 1'b1, 4'(1 << ((k + 1) % 4)), DEPTH - 1);
    for (int k = 0; k < DEPTH; k++)
      applyStimulus(4'b0000, 1'b1, 4'b0000, DEPTH - 1 - k);
    applyStimulus(4'b0000, 1'b1, 4'b0000, 0);

    // last_ptr = 1, ports 0 and 1 alternate starting with the wrap to 0.
    applyStimulus(4'b0010, 1'b1, 4'b0010, 0);
    applyStimulus(4'b0011, 1'b1, 4'b0001, 1);
    applyStimulus(4'b0011, 1'b1, 4'b0010, 1);
    applyStimulus(4'b0011, 1'b1, 4'b0001, 1);
    applyStimulus(4'b0011, 1'b1, 4'b0010, 1);
    applyStimulus(4'b0000, 1'b1, 4'b0000, 1);
    applyStimulus(4'b0000, 1'b1, 4'b0000, 0);

    // Reset with five packets buffered; priority returns to port 0.
    for (int k = 0; k < 5; k++)
      applyStimulus(4'b0001, 1'b0, 4'b0001, k);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 5);
    doReset(4'b1111);
    applyStimulus(4'b1111, 1'b1, 4'b0001, 0);
    applyStimulus(4'b1111, 1'b1, 4'b0010, 1);
    applyStimulus(4'b0000, 1'b1, 4'b0000, 1);
    applyStimulus(4'b0000, 1'b1, 4'b0000, 0);
    applyStimulus(4'b0000, 1'b1, 4'b0000, 0);

    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/tx_port.md
TX_PORT -- requirements
Module: tx_port

Interface
REQ-001 Parameter: PORT_ID, default 0, index of the output port this instance serves (0..`NUM_PORTS-1).
REQ-002 Parameter: DEPTH, default 8, output buffer entries, power of two, >=2.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_vec  input  `NUM_PORTS  bit i = rx port i holds a head packet still needing this output (pkt_valid qualified by its outstanding targets).
REQ-006 pkt_vec  input  `NUM_PORTS x packet_t  head packet of each rx port, bit-aligned with req_vec.
REQ-007 grant_vec  output  `NUM_PORTS  one-hot-or-zero grant to rx ports, combinational, same cycle as request.
REQ-008 out_pkt  output  packet_t  head of output buffer.
REQ-009 out_valid  output  1  out_pkt valid.
REQ-010 out_ready  input  1  external sink accepts out_pkt when out_valid && out_ready.
REQ-011 occupancy  output  $clog2(DEPTH)+1  entries currently buffered.

Function
REQ-012 Arbiter: round-robin over req_vec; search starts at index (last_ptr+1) mod `NUM_PORTS, wraps, first set bit wins.
REQ-013 grant_vec asserted only when buffer not full (occupancy < DEPTH) and req_vec non-zero; otherwise grant_vec = 0.
REQ-014 At most one grant_vec bit high in any cycle; grant_vec & ~req_vec always 0.
REQ-015 On grant to port g: pkt_vec[g] written to buffer tail at that rising edge; last_ptr <= g.
REQ-016 No grant: last_ptr holds.
REQ-017 No full-buffer bypass: when full, grant withheld even if a pop occurs the same cycle.
REQ-018 Buffer: circular FIFO, read/write pointers wrap modulo DEPTH; occupancy = count of stored entries.
REQ-019 Pop occurs on rising edge when out_valid && out_ready.
REQ-020 Simultaneous push and pop: occupancy unchanged, both pointers advance.
REQ-021 out_valid = (occupancy != 0); out_pkt = entry at read pointer; both stable while out_valid && !out_ready.
REQ-022 Latency: packet granted in cycle T appears on out_pkt with out_valid at cycle T+1 earliest (buffer empty, no pop-through).
REQ-023 Packet order at output equals grant order.
REQ-024 Packet fields passed unmodified; target field not rewritten.
REQ-025 Fairness: with all `NUM_PORTS requesting continuously and buffer draining, each port granted exactly once per `NUM_PORTS consecutive grants.
REQ-026 Buffer empty and out_ready high: no pop, pointers unchanged.

Reset
REQ-027 rst sampled on rising edge only; rst high overrides all other inputs that cycle.
REQ-028 On reset: occupancy=0, out_valid=0, read/write pointers=0, last_ptr=`NUM_PORTS-1 (port 0 highest priority first).
REQ-029 While rst high, grant_vec=0 regardless of req_vec.
REQ-030 Reset mid-operation discards all buffered packets; no partial entry survives.

Verification
REQ-031 After reset, req_vec=4'b1111 held, out_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles; out_pkt sequence matches pkt_vec[0..3,0].
REQ-032 req_vec=4'b0100 single cycle, buffer empty -> grant_vec=4'b0100 same cycle; out_valid=1 next cycle with pkt_vec[2]; occupancy 1 then 0 after pop.
REQ-033 out_ready=0, req_vec=4'b0001 held 10 cycles (DEPTH=8) -> 8 grants, occupancy=8, grant_vec=0 thereafter; raise out_ready with req held -> no grant in the pop cycle, grant resumes next cycle.
REQ-034 Full buffer, out_ready=1 with continuous requests -> simultaneous push/pop steady state, occupancy stays DEPTH-1..DEPTH pattern, order preserved across pointer wrap (>=3*DEPTH packets).
REQ-035 last_ptr=1, req_vec=4'b0011 -> grant port 0 (wrap), then port 1; never port 1 twice consecutively while port 0 requests.
REQ-036 occupancy=5, assert rst one cycle -> next cycle occupancy=0, out_valid=0, grant_vec=0 during rst; first post-reset grant with req_vec=4'b1111 goes to port 0.
